// File: rtl/axi4_lite_write_register_bank.sv
// rtl/axi4_lite_write_register_bank.sv - AXI4-Lite write register bank with doorbell command launch
// Optional miss counter output oUnmappedCount enabled by AXI_REG_BANK_UNMAPPED_CNT_EN.
module axi4_lite_write_register_bank #(
   parameter int                      AddressWidth = 32,
   parameter int                      DataWidth    = 32,
   parameter logic [AddressWidth-1:0] BaseAddress  = 32'h0000_0000
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [AddressWidth-1:0] iWriteAddress,
   input  logic [DataWidth-1:0]    iWriteData,
   input  logic                    iWriteValid,
   output logic                    oWriteAck,
   output logic [DataWidth-1:0]    oCtrl,
   output logic [DataWidth-1:0]    oCmdAddress,
   output logic [15:0]             oCmdLength,
   output logic                    oCmdValid,
   output logic [7:0]              oCmdOpcode,
   output logic [DataWidth-1:0]    oCmdAddrOut,
   output logic [15:0]             oCmdLenOut,
`ifdef AXI_REG_BANK_UNMAPPED_CNT_EN
   output logic [7:0]              oUnmappedCount,
`endif
   input  logic                    iCmdReady
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t                state_q;
   logic                  ack_q;
   logic [DataWidth-1:0]  ctrl_q;
   logic [DataWidth-1:0]  cmd_addr_q;
   logic [15:0]           cmd_len_q;
   logic                  cmd_valid_q;
   logic [7:0]            opcode_q;
   logic [DataWidth-1:0]  addr_out_q;
   logic [15:0]           len_out_q;

   logic       hit;
   logic [1:0] reg_sel;
   logic       is_doorbell;
   logic       commit;
   logic       unused_addr_bits;

   assign hit         = (iWriteAddress[AddressWidth-1:4] == BaseAddress[AddressWidth-1:4]);
   assign reg_sel     = iWriteAddress[3:2];
   assign is_doorbell = hit && (reg_sel == 2'd3);
   assign unused_addr_bits = ^iWriteAddress[1:0];

   // A stalled doorbell commits as soon as the pending command is gone or taken this edge.
   assign commit = ((state_q == IDLE) && iWriteValid && !(is_doorbell && cmd_valid_q)) ||
                   ((state_q == STALL) && (!cmd_valid_q || iCmdReady));

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= IDLE;
         ack_q       <= 1'b0;
         ctrl_q      <= '0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
         cmd_valid_q <= 1'b0;
         opcode_q    <= '0;
         addr_out_q  <= '0;
         len_out_q   <= '0;
      end else begin
         ack_q <= commit;
         case (state_q)
            IDLE:    if (commit) state_q <= ACK;
                     else if (iWriteValid) state_q <= STALL;
            STALL:   if (commit) state_q <= ACK;
            ACK:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase

         if (cmd_valid_q && iCmdReady) cmd_valid_q <= 1'b0;

         // A doorbell commit overrides the handshake clear so back-to-back commands never gap.
         if (commit && hit) begin
            case (reg_sel)
               2'd0: ctrl_q     <= iWriteData;
               2'd1: cmd_addr_q <= iWriteData;
               2'd2: cmd_len_q  <= iWriteData[15:0];
               default: begin
                  opcode_q    <= iWriteData[7:0];
                  addr_out_q  <= cmd_addr_q;
                  len_out_q   <= cmd_len_q;
                  cmd_valid_q <= 1'b1;
               end
            endcase
         end
      end
   end

`ifdef AXI_REG_BANK_UNMAPPED_CNT_EN
   logic [7:0] unmapped_q;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         unmapped_q <= '0;
      end else if (commit && !hit && (unmapped_q != 8'hFF)) begin
         unmapped_q <= unmapped_q + 8'd1;
      end
   end

   assign oUnmappedCount = unmapped_q;
`endif

   assign oWriteAck   = ack_q;
   assign oCtrl       = ctrl_q;
   assign oCmdAddress = cmd_addr_q;
   assign oCmdLength  = cmd_len_q;
   assign oCmdValid   = cmd_valid_q;
   assign oCmdOpcode  = opcode_q;
   assign oCmdAddrOut = addr_out_q;
   assign oCmdLenOut  = len_out_q;

endmodule
